// File: rtl/hw_stack_if.sv
// Processor data-bus side of the hardware stack: strobes in, result and status out.
interface hw_stack_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 4
);
  logic [WIDTH-1:0]  data_in;
  logic              push;
  logic              pop;
  logic              read;
  logic [ADDR_W-1:0] peek_offset;
  logic              clear;
  logic [WIDTH-1:0]  data_out;
  logic              out_valid;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  // Control decoder / bus owner side
  modport master (
    output data_in, push, pop, read, peek_offset, clear,
    input  data_out, out_valid, count, full, empty, overflow, underflow
  );

  // Stack side
  modport slave (
    input  data_in, push, pop, read, peek_offset, clear,
    output data_out, out_valid, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/hw_stack.sv
// Parametrised circular-buffer LIFO with swap, indexed peek and sticky error flags.
module hw_stack #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned OVF_MODE = 0
) (
  input  logic        clk,
  input  logic        reset,
  hw_stack_if.slave   bus
);
  localparam int unsigned CW = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic [ADDR_W-1:0] base_q, base_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  logic [ADDR_W-1:0] top_idx;
  logic [ADDR_W-1:0] tail_idx;
  logic [ADDR_W-1:0] peek_idx;
  logic              is_full;
  logic              is_empty;

  // Index arithmetic wraps naturally in ADDR_W bits; count==DEPTH truncates to 0.
  assign top_idx  = base_q + count_q[ADDR_W-1:0] - ADDR_W'(1);
  assign tail_idx = base_q + count_q[ADDR_W-1:0];
  assign peek_idx = top_idx - bus.peek_offset;
  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);

  // Next-state decode with priority clear > swap > push > pop > read
  always_comb begin
    base_d  = base_q;
    count_d = count_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_addr = tail_idx;
    wr_data = bus.data_in;

    if (bus.clear) begin
      base_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (bus.push && bus.pop) begin
      if (is_empty) begin
        // Swap on an empty stack degrades to a plain push and flags the missing pop
        wr_en   = 1'b1;
        wr_addr = tail_idx;
        count_d = count_q + CW'(1);
        unf_d   = 1'b1;
      end else begin
        dout_d  = mem[top_idx];
        valid_d = 1'b1;
        wr_en   = 1'b1;
        wr_addr = top_idx;
      end
    end else if (bus.push) begin
      if (!is_full) begin
        wr_en   = 1'b1;
        wr_addr = tail_idx;
        count_d = count_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
        if (OVF_MODE != 0) begin
          // Overwrite the oldest slot; it becomes the new top once base advances
          wr_en   = 1'b1;
          wr_addr = base_q;
          base_d  = base_q + ADDR_W'(1);
        end
      end
    end else if (bus.pop) begin
      if (is_empty) begin
        unf_d = 1'b1;
      end else begin
        dout_d  = mem[top_idx];
        valid_d = 1'b1;
        count_d = count_q - CW'(1);
      end
    end else if (bus.read) begin
      valid_d = 1'b1;
      if (CW'(bus.peek_offset) < count_q) begin
        dout_d = mem[peek_idx];
      end else begin
        dout_d = '0;
      end
    end
  end

  // Control and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      base_q  <= base_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array; contents survive reset and clear
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign bus.data_out  = dout_q;
  assign bus.out_valid = valid_q;
  assign bus.count     = count_q;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_hw_stack.sv
// Bench: three stacks (16 deep drop, 4 deep drop, 4 deep wrap) share one stimulus stream.
module tb_hw_stack;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] din = '0;
  logic        push = 1'b0, pop = 1'b0, read = 1'b0, clr = 1'b0;
  logic [3:0]  off = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hw_stack_if #(.WIDTH(16), .ADDR_W(4)) bus_a ();
  hw_stack_if #(.WIDTH(16), .ADDR_W(2)) bus_b ();
  hw_stack_if #(.WIDTH(16), .ADDR_W(2)) bus_c ();

  hw_stack #(.WIDTH(16), .DEPTH(16), .ADDR_W(4), .OVF_MODE(0)) u_a (.clk(clk), .reset(reset), .bus(bus_a));
  hw_stack #(.WIDTH(16), .DEPTH(4),  .ADDR_W(2), .OVF_MODE(0)) u_b (.clk(clk), .reset(reset), .bus(bus_b));
  hw_stack #(.WIDTH(16), .DEPTH(4),  .ADDR_W(2), .OVF_MODE(1)) u_c (.clk(clk), .reset(reset), .bus(bus_c));

  assign bus_a.data_in = din;  assign bus_b.data_in = din;  assign bus_c.data_in = din;
  assign bus_a.push = push;    assign bus_b.push = push;    assign bus_c.push = push;
  assign bus_a.pop = pop;      assign bus_b.pop = pop;      assign bus_c.pop = pop;
  assign bus_a.read = read;    assign bus_b.read = read;    assign bus_c.read = read;
  assign bus_a.clear = clr;    assign bus_b.clear = clr;    assign bus_c.clear = clr;
  assign bus_a.peek_offset = off;
  assign bus_b.peek_offset = off[1:0];
  assign bus_c.peek_offset = off[1:0];

  logic [15:0] act_dout [3];
  logic [4:0]  act_count [3];
  logic        act_valid [3], act_full [3], act_empty [3], act_ovf [3], act_unf [3];

  assign act_dout[0] = bus_a.data_out;  assign act_dout[1] = bus_b.data_out;  assign act_dout[2] = bus_c.data_out;
  assign act_count[0] = bus_a.count;    assign act_count[1] = 5'(bus_b.count); assign act_count[2] = 5'(bus_c.count);
  assign act_valid[0] = bus_a.out_valid; assign act_valid[1] = bus_b.out_valid; assign act_valid[2] = bus_c.out_valid;
  assign act_full[0] = bus_a.full;      assign act_full[1] = bus_b.full;      assign act_full[2] = bus_c.full;
  assign act_empty[0] = bus_a.empty;    assign act_empty[1] = bus_b.empty;    assign act_empty[2] = bus_c.empty;
  assign act_ovf[0] = bus_a.overflow;   assign act_ovf[1] = bus_b.overflow;   assign act_ovf[2] = bus_c.overflow;
  assign act_unf[0] = bus_a.underflow;  assign act_unf[1] = bus_b.underflow;  assign act_unf[2] = bus_c.underflow;

  // Reference model: an ordinary array stack, element 0 is the oldest entry
  logic [15:0] ms [3][16];
  int          msz [3];
  logic [15:0] mdout [3];
  bit          mv [3], movf [3], munf [3];

  function automatic int dep(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      msz[k] = 0; mdout[k] = '0; mv[k] = 0; movf[k] = 0; munf[k] = 0;
    end
  endfunction

  function automatic void model_step();
    int o;
    for (int k = 0; k < 3; k++) begin
      mv[k] = 0;
      if (clr) begin
        msz[k] = 0; movf[k] = 0; munf[k] = 0;
      end else if (push && pop) begin
        if (msz[k] == 0) begin
          ms[k][0] = din; msz[k] = 1; munf[k] = 1;
        end else begin
          mdout[k] = ms[k][msz[k]-1]; ms[k][msz[k]-1] = din; mv[k] = 1;
        end
      end else if (push) begin
        if (msz[k] < dep(k)) begin
          ms[k][msz[k]] = din; msz[k]++;
        end else begin
          movf[k] = 1;
          if (k == 2) begin
            for (int i = 0; i < dep(k) - 1; i++) ms[k][i] = ms[k][i+1];
            ms[k][dep(k)-1] = din;
          end
        end
      end else if (pop) begin
        if (msz[k] == 0) munf[k] = 1;
        else begin
          msz[k]--; mdout[k] = ms[k][msz[k]]; mv[k] = 1;
        end
      end else if (read) begin
        o = int'(off) % dep(k);
        mv[k] = 1;
        mdout[k] = (o < msz[k]) ? ms[k][msz[k]-1-o] : 16'h0000;
      end
    end
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk("data_out", k, 32'(act_dout[k]), 32'(mdout[k]));
      chk("out_valid", k, 32'(act_valid[k]), 32'(mv[k]));
      chk("count", k, 32'(act_count[k]), 32'(msz[k]));
      chk("full", k, 32'(act_full[k]), 32'(msz[k] == dep(k)));
      chk("empty", k, 32'(act_empty[k]), 32'(msz[k] == 0));
      chk("overflow", k, 32'(act_ovf[k]), 32'(movf[k]));
      chk("underflow", k, 32'(act_unf[k]), 32'(munf[k]));
    end
  endtask

  // One clock: inputs change at the falling edge, outputs checked 1 unit after the rising edge
  task automatic drive(input bit p, input bit po, input bit rd, input bit cl,
                       input logic [15:0] d, input logic [3:0] o);
    @(negedge clk);
    push = p; pop = po; read = rd; clr = cl; din = d; off = o;
    @(posedge clk);
    if (reset) model_step();
    #1;
    check_all();
  endtask

  typedef enum {OP_IDLE, OP_PUSH, OP_POP, OP_SWAP, OP_READ, OP_CLR} op_e;
  typedef struct {
    int          dut;
    op_e         op;
    logic [15:0] din;
    logic [3:0]  off;
    bit          ev;
    logic [15:0] ed;
    int          ec;
    bit          eo;
    bit          eu;
  } vec_t;

  vec_t tbl[$];

  function automatic void mk(input int dut, input op_e op, input logic [15:0] d, input logic [3:0] o,
                             input bit ev, input logic [15:0] ed, input int ec, input bit eo, input bit eu);
    vec_t v;
    v.dut = dut; v.op = op; v.din = d; v.off = o;
    v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo; v.eu = eu;
    tbl.push_back(v);
  endfunction

  initial begin
    // LIFO order on the 16-deep stack
    mk(0, OP_PUSH, 16'h1111, 0, 0, 0, 1, 0, 0);
    mk(0, OP_PUSH, 16'h2222, 0, 0, 0, 2, 0, 0);
    mk(0, OP_PUSH, 16'h3333, 0, 0, 0, 3, 0, 0);
    mk(0, OP_POP,  0, 0, 1, 16'h3333, 2, 0, 0);
    mk(0, OP_POP,  0, 0, 1, 16'h2222, 1, 0, 0);
    mk(0, OP_POP,  0, 0, 1, 16'h1111, 0, 0, 0);
    // Drop-on-full, 4 deep
    mk(1, OP_CLR,  0, 0, 0, 0, 0, 0, 0);
    mk(1, OP_PUSH, 16'd1, 0, 0, 0, 1, 0, 0);
    mk(1, OP_PUSH, 16'd2, 0, 0, 0, 2, 0, 0);
    mk(1, OP_PUSH, 16'd3, 0, 0, 0, 3, 0, 0);
    mk(1, OP_PUSH, 16'd4, 0, 0, 0, 4, 0, 0);
    mk(1, OP_PUSH, 16'd5, 0, 0, 0, 4, 1, 0);
    mk(1, OP_POP,  0, 0, 1, 16'd4, 3, 1, 0);
    mk(1, OP_POP,  0, 0, 1, 16'd3, 2, 1, 0);
    mk(1, OP_POP,  0, 0, 1, 16'd2, 1, 1, 0);
    mk(1, OP_POP,  0, 0, 1, 16'd1, 0, 1, 0);
    // Wrap-on-full, 4 deep
    mk(2, OP_CLR,  0, 0, 0, 0, 0, 0, 0);
    mk(2, OP_PUSH, 16'd1, 0, 0, 0, 1, 0, 0);
    mk(2, OP_PUSH, 16'd2, 0, 0, 0, 2, 0, 0);
    mk(2, OP_PUSH, 16'd3, 0, 0, 0, 3, 0, 0);
    mk(2, OP_PUSH, 16'd4, 0, 0, 0, 4, 0, 0);
    mk(2, OP_PUSH, 16'd5, 0, 0, 0, 4, 1, 0);
    mk(2, OP_PUSH, 16'd6, 0, 0, 0, 4, 1, 0);
    mk(2, OP_POP,  0, 0, 1, 16'd6, 3, 1, 0);
    mk(2, OP_POP,  0, 0, 1, 16'd5, 2, 1, 0);
    mk(2, OP_POP,  0, 0, 1, 16'd4, 1, 1, 0);
    mk(2, OP_POP,  0, 0, 1, 16'd3, 0, 1, 0);
    // Swap
    mk(0, OP_CLR,  0, 0, 0, 0, 0, 0, 0);
    mk(0, OP_PUSH, 16'h000A, 0, 0, 0, 1, 0, 0);
    mk(0, OP_PUSH, 16'h000B, 0, 0, 0, 2, 0, 0);
    mk(0, OP_SWAP, 16'h000C, 0, 1, 16'h000B, 2, 0, 0);
    mk(0, OP_POP,  0, 0, 1, 16'h000C, 1, 0, 0);
    mk(0, OP_POP,  0, 0, 1, 16'h000A, 0, 0, 0);
    // Peek, including an offset past the valid entries
    mk(0, OP_CLR,  0, 0, 0, 0, 0, 0, 0);
    mk(0, OP_PUSH, 16'h0010, 0, 0, 0, 1, 0, 0);
    mk(0, OP_PUSH, 16'h0020, 0, 0, 0, 2, 0, 0);
    mk(0, OP_PUSH, 16'h0030, 0, 0, 0, 3, 0, 0);
    mk(0, OP_READ, 0, 4'd0, 1, 16'h0030, 3, 0, 0);
    mk(0, OP_READ, 0, 4'd2, 1, 16'h0010, 3, 0, 0);
    mk(0, OP_READ, 0, 4'd3, 1, 16'h0000, 3, 0, 0);
    // Underflow and its clearing, then swap on empty
    mk(0, OP_CLR,  0, 0, 0, 0, 0, 0, 0);
    mk(0, OP_POP,  0, 0, 0, 0, 0, 0, 1);
    mk(0, OP_CLR,  0, 0, 0, 0, 0, 0, 0);
    mk(0, OP_SWAP, 16'h0005, 0, 0, 0, 1, 0, 1);
    mk(0, OP_POP,  0, 0, 1, 16'h0005, 0, 0, 1);
    mk(0, OP_CLR,  0, 0, 0, 0, 0, 0, 0);
  end

  initial begin
    model_reset();
    #2 reset = 1'b0;
    #1 check_all();
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      drive(v.op == OP_PUSH || v.op == OP_SWAP, v.op == OP_POP || v.op == OP_SWAP,
            v.op == OP_READ, v.op == OP_CLR, v.din, v.off);
      chk("tbl count", v.dut, 32'(act_count[v.dut]), 32'(v.ec));
      chk("tbl out_valid", v.dut, 32'(act_valid[v.dut]), 32'(v.ev));
      if (v.ev) chk("tbl data_out", v.dut, 32'(act_dout[v.dut]), 32'(v.ed));
      chk("tbl full", v.dut, 32'(act_full[v.dut]), 32'(v.ec == dep(v.dut)));
      chk("tbl empty", v.dut, 32'(act_empty[v.dut]), 32'(v.ec == 0));
      chk("tbl overflow", v.dut, 32'(act_ovf[v.dut]), 32'(v.eo));
      chk("tbl underflow", v.dut, 32'(act_unf[v.dut]), 32'(v.eu));
    end

    // Reset asserted while a pop is pending
    drive(1, 0, 0, 0, 16'h0077, 0);
    @(negedge clk);
    push = 1'b0; pop = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst count", k, 32'(act_count[k]), 32'd0);
      chk("rst out_valid", k, 32'(act_valid[k]), 32'd0);
      chk("rst data_out", k, 32'(act_dout[k]), 32'd0);
    end
    @(posedge clk); #1;
    check_all();
    @(negedge clk);
    pop = 1'b0; reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) chk("post-rst out_valid", k, 32'(act_valid[k]), 32'd0);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit cl;
      cl = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, cl,
            16'($urandom), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hw_stack.md
Name: hw_stack

Overview:
- Parametrised hardware LIFO stack. Generalises the fixed 16-bit SP-plus-memory stack: WIDTH, DEPTH and overflow policy are parameters.
- Adds a single-cycle PUSH/POP swap, indexed peek, and sticky overflow/underflow flags.
- Sits on the processor data bus. The control decoder strobes push/pop/read. data_out is returned to the bus through the owner's tri-state/mux, qualified by out_valid.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 16, number of entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); must be consistent with DEPTH.
- OVF_MODE, 0, 0 = drop (push when full is ignored), 1 = wrap (push when full overwrites the oldest entry).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; reset=0 clears all state.
- data_in  in  WIDTH  word to push.
- push  in  1  push strobe.
- pop  in  1  pop strobe.
- read  in  1  peek strobe; non-destructive.
- peek_offset  in  ADDR_W  peek depth; 0 = top of stack.
- clear  in  1  synchronous flush of contents, count and flags.
- data_out  out  WIDTH  registered read/pop result.
- out_valid  out  1  one-cycle pulse; data_out updated this cycle.
- count  out  ADDR_W+1  number of valid entries, 0..DEPTH.
- full  out  1  count == DEPTH (combinational from count).
- empty  out  1  count == 0 (combinational from count).
- overflow  out  1  sticky; push attempted while full.
- underflow  out  1  sticky; pop attempted while empty.

Behaviour:
- Reset (reset=0, async): count=0, internal base/top pointers=0, data_out=0, out_valid=0, overflow=0, underflow=0.
  - Storage array is not cleared.
  - A reset mid-operation aborts any pending result; out_valid stays 0 on the first edge after release.
- Storage: DEPTH x WIDTH register array, circular.
  - top index = (base + count - 1) mod DEPTH. Pointer arithmetic wraps modulo DEPTH.
- Per-edge priority: clear > (push&pop) > push > pop > read.
- Lower-priority strobes in the same cycle are ignored. Exception: read combined with pop or push&pop is ignored without error.
- clear: count=0, base=0, overflow=0, underflow=0, out_valid=0. data_out holds its value.
- push only:
  - Not full: mem[(base+count) mod DEPTH] <= data_in; count+1.
  - Full, OVF_MODE=0: no write; count unchanged; overflow<=1.
  - Full, OVF_MODE=1: mem[base] <= data_in; base+1; count stays DEPTH; overflow<=1.
- pop only:
  - Not empty: data_out <= mem[top]; count-1; out_valid pulses next cycle.
  - Empty: underflow<=1; data_out unchanged; out_valid stays 0.
- push&pop (swap):
  - Not empty: data_out <= mem[top]; mem[top] <= data_in; count unchanged; out_valid pulses; no flags change.
  - Empty: behaves as push only; underflow<=1; out_valid stays 0.
- read only:
  - peek_offset < count: data_out <= mem[(top - peek_offset) mod DEPTH]; out_valid pulses.
  - peek_offset >= count: data_out <= 0; out_valid pulses; no flag change.
- Latency: all results are registered and visible 1 cycle after the strobe edge.
  - out_valid is high for exactly one cycle per accepted pop/swap/read.
  - Back-to-back strobes give back-to-back pulses.
- Flags overflow and underflow are sticky: set by the events above, cleared only by clear or reset.
- full and empty follow count with no additional latency.

Test Plan:
- Reset, push 0x1111, 0x2222, 0x3333, then three pops -> data_out 0x3333, 0x2222, 0x1111 on consecutive out_valid pulses; count 3->0; empty=1; no flags set.
- OVF_MODE=0, DEPTH=4: push 1,2,3,4,5 -> full=1 after 4th push; overflow=1 after 5th; four pops return 4,3,2,1.
- OVF_MODE=1, DEPTH=4: push 1..6 -> count=4, overflow=1; pops return 6,5,4,3; then empty=1.
- Push 0xA, 0xB; assert push&pop with data_in 0xC -> data_out=0xB, count=2; subsequent pops return 0xC, 0xA.
- Push 0x10, 0x20, 0x30; read with peek_offset 0/2/3 -> data_out 0x30, 0x10, 0x0000; count stays 3 throughout.
- Empty stack: pop -> underflow=1, out_valid=0; clear -> underflow=0. Separately, assert reset=0 during a pop cycle -> count=0, out_valid=0, data_out=0.
